// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide engine for the EX stage: pipelined multiplier plus an iterative radix-2^k divider.
// Optional MULDIV_EARLY_OUT_EN: divides with |dividend| < |divisor| complete in one cycle.
package ex_muldiv_pkg;
    typedef enum logic [1:0] {
        FW_NONE    = 2'd0,
        FW_MEM_ALU = 2'd1,
        FW_WB_DATA = 2'd2
    } fw_sel_e;
endpackage

module ex_muldiv_unit
    import ex_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH         = 32,
    parameter int MUL_STAGES         = 2,
    parameter int DIV_BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic                  flush_i,
    input  logic [2:0]            funct3_i,
    input  fw_sel_e               forwardA_i,
    input  fw_sel_e               forwardB_i,
    input  logic [DATA_WIDTH-1:0] rd_data1_i,
    input  logic [DATA_WIDTH-1:0] rd_data2_i,
    input  logic [DATA_WIDTH-1:0] alu_result_MEM_i,
    input  logic [DATA_WIDTH-1:0] wb_data_WB_i,
    output logic                  busy_o,
    output logic                  result_valid_o,
    output logic [DATA_WIDTH-1:0] result_o
);
    localparam int W  = DATA_WIDTH;
    localparam int K  = DIV_BITS_PER_CYCLE;
    localparam int N  = W / K;
    localparam int PD = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;
    localparam int CW = $clog2(N + MUL_STAGES + 1) + 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            upper_q, upper_d;      // MUL: high half; DIV: remainder
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [W-1:0]    quo_q, quo_d;
    logic [W-1:0]    rem_q, rem_d;
    logic [W-1:0]    dvsr_q, dvsr_d;
    logic [W-1:0]    result_q, result_d;
    logic            result_valid_q, result_valid_d;
    logic [2*W-1:0]  prod_pipe_q [PD];

    logic            issue;
    logic [W-1:0]    op_a, op_b;
    logic            sgn, a_neg, b_neg, div0, ovf, early;
    logic [W-1:0]    a_mag, b_mag;
    logic [2*W-1:0]  ma, mb, prod_now, mul_res;
    logic [W:0]      rem_t;
    logic [W-1:0]    quo_t, q_fin, r_fin;

    function automatic logic [W-1:0] fwd(fw_sel_e sel, logic [W-1:0] rd,
                                         logic [W-1:0] mem, logic [W-1:0] wb);
        case (sel)
            FW_MEM_ALU: return mem;
            FW_WB_DATA: return wb;
            default:    return rd;
        endcase
    endfunction

    function automatic logic [W-1:0] mul_half(logic hi, logic [2*W-1:0] p);
        return hi ? p[2*W-1:W] : p[W-1:0];
    endfunction

    always_comb begin
        op_a  = fwd(forwardA_i, rd_data1_i, alu_result_MEM_i, wb_data_WB_i);
        op_b  = fwd(forwardB_i, rd_data2_i, alu_result_MEM_i, wb_data_WB_i);
        issue = (state_q == S_IDLE) && valid_i && !flush_i;
        busy_o = (state_q != S_DONE) && ((state_q != S_IDLE) || issue);
    end

    // Lower 2W bits of the product do not depend on extension beyond 2W.
    always_comb begin
        ma = (funct3_i != 3'b011) ? {{W{op_a[W-1]}}, op_a} : {{W{1'b0}}, op_a};
        mb = (funct3_i[1] == 1'b0) ? {{W{op_b[W-1]}}, op_b} : {{W{1'b0}}, op_b};
        prod_now = ma * mb;
        mul_res  = (MUL_STAGES == 1) ? prod_now : prod_pipe_q[PD-1];
    end

    always_comb begin
        sgn   = !funct3_i[0];
        a_neg = sgn && op_a[W-1];
        b_neg = sgn && op_b[W-1];
        a_mag = a_neg ? -op_a : op_a;
        b_mag = b_neg ? -op_b : op_b;
        div0  = (op_b == '0);
        ovf   = sgn && (op_a == {1'b1, {(W-1){1'b0}}}) && (op_b == '1);
`ifdef MULDIV_EARLY_OUT_EN
        early = !div0 && (a_mag < b_mag);
`else
        early = 1'b0;
`endif
    end

    // K restoring-division steps per cycle, then sign correction for the final cycle.
    always_comb begin
        rem_t = {1'b0, rem_q};
        quo_t = quo_q;
        for (int i = 0; i < K; i++) begin
            rem_t = {rem_t[W-1:0], quo_t[W-1]};
            quo_t = {quo_t[W-2:0], 1'b0};
            if (rem_t >= {1'b0, dvsr_q}) begin
                rem_t    = rem_t - {1'b0, dvsr_q};
                quo_t[0] = 1'b1;
            end
        end
        q_fin = neg_quo_q ? -quo_t : quo_t;
        r_fin = neg_rem_q ? -rem_t[W-1:0] : rem_t[W-1:0];
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        upper_d        = upper_q;
        neg_quo_d      = neg_quo_q;
        neg_rem_d      = neg_rem_q;
        quo_d          = quo_q;
        rem_d          = rem_q;
        dvsr_d         = dvsr_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        case (state_q)
            S_IDLE: if (issue) begin
                if (!funct3_i[2]) begin
                    upper_d = (funct3_i[1:0] != 2'b00);
                    if (MUL_STAGES == 1) begin
                        state_d        = S_DONE;
                        result_d       = mul_half(funct3_i[1:0] != 2'b00, prod_now);
                        result_valid_d = 1'b1;
                    end else begin
                        state_d = S_MUL;
                        cnt_d   = CW'(1);
                    end
                end else if (div0 || ovf || early) begin
                    state_d        = S_DONE;
                    result_valid_d = 1'b1;
                    if (div0)     result_d = funct3_i[1] ? op_a : '1;
                    else if (ovf) result_d = funct3_i[1] ? '0 : op_a;
                    else          result_d = funct3_i[1] ? op_a : '0;
                end else begin
                    state_d   = S_DIV;
                    cnt_d     = '0;
                    upper_d   = funct3_i[1];
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    quo_d     = a_mag;
                    rem_d     = '0;
                    dvsr_d    = b_mag;
                end
            end
            S_MUL: begin
                if (cnt_q == CW'(MUL_STAGES - 1)) begin
                    state_d        = S_DONE;
                    result_d       = mul_half(upper_q, mul_res);
                    result_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DIV: begin
                quo_d = quo_t;
                rem_d = rem_t[W-1:0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d        = S_DONE;
                    result_d       = upper_q ? r_fin : q_fin;
                    result_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_i) begin
            state_d        = S_IDLE;
            result_d       = result_q;
            result_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            upper_q        <= 1'b0;
            neg_quo_q      <= 1'b0;
            neg_rem_q      <= 1'b0;
            quo_q          <= '0;
            rem_q          <= '0;
            dvsr_q         <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            upper_q        <= upper_d;
            neg_quo_q      <= neg_quo_d;
            neg_rem_q      <= neg_rem_d;
            quo_q          <= quo_d;
            rem_q          <= rem_d;
            dvsr_q         <= dvsr_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    // Free-running product pipeline; slot k holds the product issued k+1 cycles ago.
    always_ff @(posedge clk) begin
        prod_pipe_q[0] <= prod_now;
        for (int i = 1; i < PD; i++) prod_pipe_q[i] <= prod_pipe_q[i-1];
    end

    assign result_valid_o = result_valid_q;
    assign result_o       = result_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: issue side pushes reference results, a monitor pops on result_valid_o.
module tb_ex_muldiv_unit;
    import ex_muldiv_pkg::*;
    localparam int MS = 2;
    localparam int N  = 32;
    localparam logic [31:0] MIN = 32'h8000_0000;

    logic        clk = 1'b0, rst = 1'b1, valid_i = 1'b0, flush_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    fw_sel_e     forwardA_i = FW_NONE, forwardB_i = FW_NONE;
    logic [31:0] rd_data1_i = '0, rd_data2_i = '0, alu_result_MEM_i = '0, wb_data_WB_i = '0;
    logic        busy_o, result_valid_o;
    logic [31:0] result_o;

    ex_muldiv_unit #(.DATA_WIDTH(32), .MUL_STAGES(MS), .DIV_BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i), .funct3_i(funct3_i),
        .forwardA_i(forwardA_i), .forwardB_i(forwardB_i),
        .rd_data1_i(rd_data1_i), .rd_data2_i(rd_data2_i),
        .alu_result_MEM_i(alu_result_MEM_i), .wb_data_WB_i(wb_data_WB_i),
        .busy_o(busy_o), .result_valid_o(result_valid_o), .result_o(result_o));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] res; int due; int id; } exp_t;
    exp_t sbq[$];
    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        logic [63:0] p;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN && b == 32'hFFFF_FFFF) return MIN;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] am, bm;
        if (!f3[2]) return MS;
        if (b == 0) return 1;
        if (!f3[0] && a == MIN && b == 32'hFFFF_FFFF) return 1;
        am = (!f3[0] && a[31]) ? -a : a;
        bm = (!f3[0] && b[31]) ? -b : b;
`ifdef MULDIV_EARLY_OUT_EN
        if (am < bm) return 1;
`else
        if (am < bm && 1'b0) return 1;
`endif
        return N + 1;
    endfunction

    function automatic logic [31:0] pick_src(input fw_sel_e s, input logic [31:0] rd,
                                             input logic [31:0] mem, input logic [31:0] wb);
        if (s == FW_MEM_ALU) return mem;
        if (s == FW_WB_DATA) return wb;
        return rd;
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return MIN;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every result pulse must match the head of the scoreboard, value and cycle.
    always @(negedge clk) begin
        if (result_valid_o) begin
            if (sbq.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = sbq.pop_front();
                chk($sformatf("result_op%0d", e.id), result_o, e.res);
                chk($sformatf("latency_op%0d", e.id), cyc, e.due);
            end
        end
    end

    task automatic do_op(input int id, input logic [2:0] f3, input fw_sel_e fa, input fw_sel_e fb,
                         input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] mem, input logic [31:0] wb);
        logic [31:0] a, b;
        bit seen;
        @(negedge clk);
        funct3_i = f3; forwardA_i = fa; forwardB_i = fb;
        rd_data1_i = rd1; rd_data2_i = rd2; alu_result_MEM_i = mem; wb_data_WB_i = wb;
        valid_i = 1'b1;
        a = pick_src(fa, rd1, mem, wb);
        b = pick_src(fb, rd2, mem, wb);
        sbq.push_back('{ref_res(f3, a, b), cyc + ref_lat(f3, a, b), id});
        #1 chk("busy_issue", {31'b0, busy_o}, 32'd1);
        seen = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (result_valid_o) begin
                seen = 1;
                chk("busy_done", {31'b0, busy_o}, 32'd0);
                valid_i = 1'b0;
            end else begin
                chk("busy_stall", {31'b0, busy_o}, 32'd1);
                // Operand sources move while stalled; the unit must hold what it latched.
                funct3_i = 3'($urandom); rd_data1_i = $urandom; rd_data2_i = $urandom;
                alu_result_MEM_i = (k == 0) ? 32'd99 : $urandom; wb_data_WB_i = $urandom;
                forwardA_i = fw_sel_e'($urandom_range(0, 3));
            end
        end
        valid_i = 1'b0;
        if (!seen) chk("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_result", result_o, 32'd0);
        chk("reset_valid", {31'b0, result_valid_o}, 32'd0);
        chk("reset_busy", {31'b0, busy_o}, 32'd0);
        rst = 1'b0;

        do_op(1, 3'd0, FW_NONE, FW_NONE, 32'd7, 32'hFFFF_FFFD, 0, 0);
        do_op(2, 3'd3, FW_NONE, FW_NONE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        do_op(3, 3'd2, FW_NONE, FW_NONE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        do_op(4, 3'd4, FW_NONE, FW_NONE, 32'hFFFF_FFF9, 32'd2, 0, 0);
        do_op(5, 3'd6, FW_NONE, FW_NONE, 32'hFFFF_FFF9, 32'd2, 0, 0);
        do_op(6, 3'd5, FW_NONE, FW_NONE, 32'd5, 32'd0, 0, 0);
        do_op(7, 3'd6, FW_NONE, FW_NONE, MIN, 32'hFFFF_FFFF, 0, 0);
        do_op(8, 3'd0, FW_MEM_ALU, FW_NONE, 32'd123, 32'd5, 32'd6, 32'd77);
        do_op(9, 3'd5, FW_NONE, FW_WB_DATA, 32'd100, 32'd1, 32'd9, 32'd7);
        do_op(10, 3'd1, fw_sel_e'(2'd3), FW_NONE, MIN, MIN, 32'd1, 32'd1);

        // Flush a divide at cycle 10: back to IDLE at cycle 11, no pulse.
        begin
            @(negedge clk);
            funct3_i = 3'd4; forwardA_i = FW_NONE; forwardB_i = FW_NONE;
            rd_data1_i = 32'd1000; rd_data2_i = 32'd7; valid_i = 1'b1;
            repeat (10) @(negedge clk);
            valid_i = 1'b0; flush_i = 1'b1;
            #1 chk("busy_before_flush", {31'b0, busy_o}, 32'd1);
            @(negedge clk);
            flush_i = 1'b0;
            #1 chk("busy_after_flush", {31'b0, busy_o}, 32'd0);
            repeat (40) @(negedge clk);
        end
        do_op(11, 3'd0, FW_NONE, FW_NONE, 32'd12, 32'd11, 0, 0);

        // Reset mid-divide clears the result and drops the op.
        begin
            @(negedge clk);
            funct3_i = 3'd5; rd_data1_i = 32'hDEAD_BEEF; rd_data2_i = 32'd3; valid_i = 1'b1;
            repeat (5) @(negedge clk);
            valid_i = 1'b0; rst = 1'b1;
            @(negedge clk);
            chk("midop_reset_result", result_o, 32'd0);
            chk("midop_reset_busy", {31'b0, busy_o}, 32'd0);
            rst = 1'b0;
            repeat (40) @(negedge clk);
        end

        for (int i = 0; i < 40; i++)
            do_op(100 + i, 3'($urandom_range(0, 7)), fw_sel_e'($urandom_range(0, 3)),
                  fw_sel_e'($urandom_range(0, 3)), pick_val(), pick_val(), pick_val(), pick_val());

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
